dpe_multiplexer: RTL and testbench

Packet-level 5:1 arbiter that merges the CPU and four Ethernet ingress streams into the single DPE input stream. It is the ingress counterpart of the DPE egress demultiplexer. It grants one source at a time, in round-robin order with optional CPU priority. It holds the grant for a whole packet and forwards beats through a registered two-entry skid stage to `to_dpe`.

---
 rtl/dpe_multiplexer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_dpe_multiplexer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpe_multiplexer.sv
// dpe_multiplexer
//
// Packet-level 5:1 ingress arbiter. Merges the CPU stream (port 0) and four
// Ethernet streams (ports 1..4) into the single DPE input stream. One source
// is granted per packet, chosen round-robin. With CPU_PRIO=1 the CPU wins
// every arbitration it requests in. Beats pass through a registered
// two-entry skid stage.
//
// Build option: define DPE_MUX_SRC_STAMP_EN to overwrite tuser_src of every
// forwarded beat with the ingress port address. Otherwise tuser_src passes
// through unchanged.
//
// Ports:
//   sys_clk, sys_rst_n        clock, asynchronous active-low reset
//   from_cpu_*                CPU ingress stream (AXI-stream slave)
//   from_eth_1_* .. _4_*      Ethernet ingress streams (AXI-stream slaves)
//   to_dpe_*                  merged stream (AXI-stream master)
//   dbg_state                 0 = IDLE, 1 = BUSY
//   dbg_grant, dbg_rr_ptr     granted port, round-robin start pointer
//   dbg_skid_occ              skid stage occupancy (0..2)
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both 1. A master holds tvalid and all fields stable until that transfer.
// tvalid never depends on tready.
//
// tuser layout: {bypass_all[7], bypass_stage[6], src[5:3], dst[2:0]}.

module dpe_multiplexer #(
   parameter int CPU_PRIO = 0
) (
   input  logic         sys_clk,
   input  logic         sys_rst_n,

   input  logic         from_cpu_tvalid,
   output logic         from_cpu_tready,
   input  logic [127:0] from_cpu_tdata,
   input  logic [15:0]  from_cpu_tkeep,
   input  logic         from_cpu_tlast,
   input  logic [7:0]   from_cpu_tuser,

   input  logic         from_eth_1_tvalid,
   output logic         from_eth_1_tready,
   input  logic [127:0] from_eth_1_tdata,
   input  logic [15:0]  from_eth_1_tkeep,
   input  logic         from_eth_1_tlast,
   input  logic [7:0]   from_eth_1_tuser,

   input  logic         from_eth_2_tvalid,
   output logic         from_eth_2_tready,
   input  logic [127:0] from_eth_2_tdata,
   input  logic [15:0]  from_eth_2_tkeep,
   input  logic         from_eth_2_tlast,
   input  logic [7:0]   from_eth_2_tuser,

   input  logic         from_eth_3_tvalid,
   output logic         from_eth_3_tready,
   input  logic [127:0] from_eth_3_tdata,
   input  logic [15:0]  from_eth_3_tkeep,
   input  logic         from_eth_3_tlast,
   input  logic [7:0]   from_eth_3_tuser,

   input  logic         from_eth_4_tvalid,
   output logic         from_eth_4_tready,
   input  logic [127:0] from_eth_4_tdata,
   input  logic [15:0]  from_eth_4_tkeep,
   input  logic         from_eth_4_tlast,
   input  logic [7:0]   from_eth_4_tuser,

   output logic         to_dpe_tvalid,
   input  logic         to_dpe_tready,
   output logic [127:0] to_dpe_tdata,
   output logic [15:0]  to_dpe_tkeep,
   output logic         to_dpe_tlast,
   output logic [7:0]   to_dpe_tuser,

   output logic         dbg_state,
   output logic [2:0]   dbg_grant,
   output logic [2:0]   dbg_rr_ptr,
   output logic [1:0]   dbg_skid_occ
);

   // Beat packing: {tuser[152:145], tlast[144], tkeep[143:128], tdata[127:0]}
   localparam int BEAT_W = 153;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t            state;
   logic [2:0]        grant;
   logic [2:0]        rr_ptr;
   logic [2:0]        winner;
   logic [4:0]        req;
   logic [BEAT_W-1:0] in_beat [5];
   logic [BEAT_W-1:0] sel_beat;
   logic [BEAT_W-1:0] push_beat;
   logic              sel_valid;
   logic              push;
   logic              pop;
   logic              accept_last;
   logic [4:0]        ready_vec;

   logic [BEAT_W-1:0] ent0;
   logic [BEAT_W-1:0] ent1;
   logic              v0;
   logic              v1;
   logic              skid_not_full;
   logic [1:0]        occ;
   logic [1:0]        occ_next;

   always_comb begin
      req = {from_eth_4_tvalid, from_eth_3_tvalid, from_eth_2_tvalid,
             from_eth_1_tvalid, from_cpu_tvalid};
      in_beat[0] = {from_cpu_tuser, from_cpu_tlast, from_cpu_tkeep, from_cpu_tdata};
      in_beat[1] = {from_eth_1_tuser, from_eth_1_tlast, from_eth_1_tkeep, from_eth_1_tdata};
      in_beat[2] = {from_eth_2_tuser, from_eth_2_tlast, from_eth_2_tkeep, from_eth_2_tdata};
      in_beat[3] = {from_eth_3_tuser, from_eth_3_tlast, from_eth_3_tkeep, from_eth_3_tdata};
      in_beat[4] = {from_eth_4_tuser, from_eth_4_tlast, from_eth_4_tkeep, from_eth_4_tdata};
   end

   // First requester at or after rr_ptr, wrapping 4 -> 0; CPU override last.
   always_comb begin
      logic       found;
      logic [3:0] sum;
      logic [2:0] idx;
      winner = rr_ptr;
      found  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sum = {1'b0, rr_ptr} + 4'(i);
         idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
      if (CPU_PRIO != 0 && req[0]) winner = 3'd0;
   end

   always_comb begin
      case (grant)
         3'd1:    begin sel_beat = in_beat[1]; sel_valid = req[1]; end
         3'd2:    begin sel_beat = in_beat[2]; sel_valid = req[2]; end
         3'd3:    begin sel_beat = in_beat[3]; sel_valid = req[3]; end
         3'd4:    begin sel_beat = in_beat[4]; sel_valid = req[4]; end
         default: begin sel_beat = in_beat[0]; sel_valid = req[0]; end
      endcase
   end

`ifdef DPE_MUX_SRC_STAMP_EN
   localparam logic [2:0] DPE_ADDR_CPU   = 3'd1;
   localparam logic [2:0] DPE_ADDR_ETH_1 = 3'd2;
   localparam logic [2:0] DPE_ADDR_ETH_2 = 3'd3;
   localparam logic [2:0] DPE_ADDR_ETH_3 = 3'd4;
   localparam logic [2:0] DPE_ADDR_ETH_4 = 3'd5;

   function automatic logic [2:0] port_addr(input logic [2:0] p);
      case (p)
         3'd1:    port_addr = DPE_ADDR_ETH_1;
         3'd2:    port_addr = DPE_ADDR_ETH_2;
         3'd3:    port_addr = DPE_ADDR_ETH_3;
         3'd4:    port_addr = DPE_ADDR_ETH_4;
         default: port_addr = DPE_ADDR_CPU;
      endcase
   endfunction

   always_comb begin
      push_beat           = sel_beat;
      push_beat[150:148]  = port_addr(grant);   // tuser_src field
   end
`else
   always_comb begin
      push_beat = sel_beat;
   end
`endif

   // Only the granted port sees ready, and only while the skid has room.
   always_comb begin
      ready_vec = '0;
      if (state == BUSY && skid_not_full) ready_vec = 5'(5'b00001 << grant);
   end

   assign from_cpu_tready   = ready_vec[0];
   assign from_eth_1_tready = ready_vec[1];
   assign from_eth_2_tready = ready_vec[2];
   assign from_eth_3_tready = ready_vec[3];
   assign from_eth_4_tready = ready_vec[4];

   assign push        = (state == BUSY) && sel_valid && skid_not_full;
   assign accept_last = push && sel_beat[144];
   assign pop         = v0 && to_dpe_tready;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state  <= IDLE;
         grant  <= 3'd0;
         rr_ptr <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  grant <= winner;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (accept_last) begin
                  rr_ptr <= (grant == 3'd4) ? 3'd0 : grant + 3'd1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign occ = {1'b0, v0} + {1'b0, v1};

   always_comb begin
      occ_next = occ;
      if (push && !pop)      occ_next = occ + 2'd1;
      else if (!push && pop) occ_next = occ - 2'd1;
   end

   // Entry 0 is the output head; entry 1 only holds a beat while entry 0 does.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ent0          <= '0;
         ent1          <= '0;
         v0            <= 1'b0;
         v1            <= 1'b0;
         skid_not_full <= 1'b1;
      end else begin
         if (pop) begin
            if (v1) begin
               ent0 <= ent1;
               if (push) ent1 <= push_beat;
               else      v1   <= 1'b0;
            end else if (push) begin
               ent0 <= push_beat;
            end else begin
               v0 <= 1'b0;
            end
         end else if (push) begin
            if (!v0) begin
               ent0 <= push_beat;
               v0   <= 1'b1;
            end else begin
               ent1 <= push_beat;
               v1   <= 1'b1;
            end
         end
         // Registered room flag: a push is only offered when at most one
         // entry is in use, so it can never overflow even without a pop.
         skid_not_full <= (occ_next <= 2'd1);
      end
   end

   assign to_dpe_tvalid = v0;
   assign to_dpe_tdata  = ent0[127:0];
   assign to_dpe_tkeep  = ent0[143:128];
   assign to_dpe_tlast  = ent0[144];
   assign to_dpe_tuser  = ent0[152:145];

   assign dbg_state    = (state == BUSY);
   assign dbg_grant    = grant;
   assign dbg_rr_ptr   = rr_ptr;
   assign dbg_skid_occ = occ;

endmodule

// File: tb/tb_dpe_multiplexer.sv
// tb_dpe_multiplexer
//
// Directed bench for dpe_multiplexer. u_dut (CPU_PRIO=0) covers reset,
// round-robin, backpressure, source stamping and reset mid-packet.
// u_prio (CPU_PRIO=1) covers CPU priority.
// Source index 0..4 feed u_dut (CPU, ETH_1..4); 5 and 6 feed u_prio CPU and
// ETH_2. Each source replays beats from its own table.

module tb_dpe_multiplexer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic [6:0]   s_valid;
   logic [6:0]   s_last;
   logic [127:0] s_data [7];
   logic [15:0]  s_keep [7];
   logic [7:0]   s_user [7];
   wire  [6:0]   s_ready;

   logic         to_ready;
   wire          to_valid, to_last;
   wire [127:0]  to_data;
   wire [15:0]   to_keep;
   wire [7:0]    to_user;
   wire          dbg_state;
   wire [2:0]    dbg_grant, dbg_rr;
   wire [1:0]    dbg_occ;

   wire          p_valid, p_last;
   wire [127:0]  p_data;
   wire [15:0]   p_keep;
   wire [7:0]    p_user;
   wire          p_state;
   wire [2:0]    p_grant, p_rr;
   wire [1:0]    p_occ;
   wire [2:0]    p_unused_ready;

   // Source beat tables
   logic [152:0] mem [7][32];
   int           rd [7];
   int           cnt [7];
   logic [6:0]   acc = '0;
   int           sink_mode = 0;
   int           pat = 0;

   // Observation logs
   logic [152:0] obs_mem [64];
   int           obs_cyc [64];
   int           obs_n = 0;
   int           acc_cyc [64];
   int           acc_n = 0;
   logic [152:0] pobs_mem [32];
   int           pobs_n = 0;
   int           cyc = 0;
   int           max_occ = 0;
   int           stab_err = 0;
   int           eth2_err = 0;
   logic         hold = 1'b0;
   logic [153:0] held = '0;

   int total = 0;
   int bad = 0;

   dpe_multiplexer #(.CPU_PRIO(0)) u_dut (
      .sys_clk(clk), .sys_rst_n(rst_n),
      .from_cpu_tvalid(s_valid[0]), .from_cpu_tready(s_ready[0]),
      .from_cpu_tdata(s_data[0]), .from_cpu_tkeep(s_keep[0]),
      .from_cpu_tlast(s_last[0]), .from_cpu_tuser(s_user[0]),
      .from_eth_1_tvalid(s_valid[1]), .from_eth_1_tready(s_ready[1]),
      .from_eth_1_tdata(s_data[1]), .from_eth_1_tkeep(s_keep[1]),
      .from_eth_1_tlast(s_last[1]), .from_eth_1_tuser(s_user[1]),
      .from_eth_2_tvalid(s_valid[2]), .from_eth_2_tready(s_ready[2]),
      .from_eth_2_tdata(s_data[2]), .from_eth_2_tkeep(s_keep[2]),
      .from_eth_2_tlast(s_last[2]), .from_eth_2_tuser(s_user[2]),
      .from_eth_3_tvalid(s_valid[3]), .from_eth_3_tready(s_ready[3]),
      .from_eth_3_tdata(s_data[3]), .from_eth_3_tkeep(s_keep[3]),
      .from_eth_3_tlast(s_last[3]), .from_eth_3_tuser(s_user[3]),
      .from_eth_4_tvalid(s_valid[4]), .from_eth_4_tready(s_ready[4]),
      .from_eth_4_tdata(s_data[4]), .from_eth_4_tkeep(s_keep[4]),
      .from_eth_4_tlast(s_last[4]), .from_eth_4_tuser(s_user[4]),
      .to_dpe_tvalid(to_valid), .to_dpe_tready(to_ready),
      .to_dpe_tdata(to_data), .to_dpe_tkeep(to_keep),
      .to_dpe_tlast(to_last), .to_dpe_tuser(to_user),
      .dbg_state(dbg_state), .dbg_grant(dbg_grant),
      .dbg_rr_ptr(dbg_rr), .dbg_skid_occ(dbg_occ)
   );

   dpe_multiplexer #(.CPU_PRIO(1)) u_prio (
      .sys_clk(clk), .sys_rst_n(rst_n),
      .from_cpu_tvalid(s_valid[5]), .from_cpu_tready(s_ready[5]),
      .from_cpu_tdata(s_data[5]), .from_cpu_tkeep(s_keep[5]),
      .from_cpu_tlast(s_last[5]), .from_cpu_tuser(s_user[5]),
      .from_eth_1_tvalid(1'b0), .from_eth_1_tready(p_unused_ready[0]),
      .from_eth_1_tdata(128'h0), .from_eth_1_tkeep(16'h0),
      .from_eth_1_tlast(1'b0), .from_eth_1_tuser(8'h0),
      .from_eth_2_tvalid(s_valid[6]), .from_eth_2_tready(s_ready[6]),
      .from_eth_2_tdata(s_data[6]), .from_eth_2_tkeep(s_keep[6]),
      .from_eth_2_tlast(s_last[6]), .from_eth_2_tuser(s_user[6]),
      .from_eth_3_tvalid(1'b0), .from_eth_3_tready(p_unused_ready[1]),
      .from_eth_3_tdata(128'h0), .from_eth_3_tkeep(16'h0),
      .from_eth_3_tlast(1'b0), .from_eth_3_tuser(8'h0),
      .from_eth_4_tvalid(1'b0), .from_eth_4_tready(p_unused_ready[2]),
      .from_eth_4_tdata(128'h0), .from_eth_4_tkeep(16'h0),
      .from_eth_4_tlast(1'b0), .from_eth_4_tuser(8'h0),
      .to_dpe_tvalid(p_valid), .to_dpe_tready(1'b1),
      .to_dpe_tdata(p_data), .to_dpe_tkeep(p_keep),
      .to_dpe_tlast(p_last), .to_dpe_tuser(p_user),
      .dbg_state(p_state), .dbg_grant(p_grant),
      .dbg_rr_ptr(p_rr), .dbg_skid_occ(p_occ)
   );

   // ---------------- clock / cycle counter ----------------
   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- helpers ----------------
   function automatic logic [2:0] addr(input int p);
      addr = 3'(p + 1);   // CPU=1, ETH_1..ETH_4 = 2..5
   endfunction

   function automatic logic [127:0] mkd(input int p, input int b);
      mkd = {56'h0, 8'(p), 56'h0, 8'(b)};
   endfunction

   function automatic logic [152:0] beat(input logic [127:0] d, input logic [15:0] k,
                                         input logic l, input logic [7:0] u);
      beat = {u, l, k, d};
   endfunction

   task automatic add_beat(input int p, input logic [152:0] bt);
      mem[p][cnt[p]] = bt;
      cnt[p]++;
   endtask

   task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic wait_obs(input int prio, input int n, input string tag);
      int t;
      t = 0;
      while (((prio != 0) ? pobs_n : obs_n) < n && t < 400) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk(tag, (prio != 0) ? pobs_n : obs_n, n);
   endtask

   // ---------------- source / sink driver ----------------
   initial begin
      for (int i = 0; i < 7; i++) begin
         rd[i] = 0;
         cnt[i] = 0;
         s_data[i] = '0;
         s_keep[i] = '0;
         s_user[i] = '0;
      end
      s_valid = '0;
      s_last = '0;
      to_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 7; i++) begin
            if (acc[i]) rd[i]++;
            if (rd[i] < cnt[i]) begin
               {s_user[i], s_last[i], s_keep[i], s_data[i]} = mem[i][rd[i]];
               s_valid[i] = 1'b1;
            end else begin
               s_valid[i] = 1'b0;
            end
         end
         if (sink_mode != 0) begin
            to_ready = ((pat % 3) == 0);
            pat++;
         end else begin
            to_ready = 1'b1;
         end
      end
   end

   // ---------------- monitor (mid-cycle sampling) ----------------
   initial forever begin
      @(negedge clk);
      acc = s_valid & s_ready;
      if (to_valid && to_ready && obs_n < 64) begin
         obs_mem[obs_n] = {to_user, to_last, to_keep, to_data};
         obs_cyc[obs_n] = cyc;
         obs_n++;
      end
      if (|acc[4:0] && acc_n < 64) begin
         acc_cyc[acc_n] = cyc;
         acc_n++;
      end
      if (int'(dbg_occ) > max_occ) max_occ = int'(dbg_occ);
      if (rst_n && hold && ({to_valid, to_user, to_last, to_keep, to_data} != held))
         stab_err++;
      hold = rst_n && to_valid && !to_ready;
      held = {to_valid, to_user, to_last, to_keep, to_data};
      if (p_valid && pobs_n < 32) begin
         pobs_mem[pobs_n] = {p_user, p_last, p_keep, p_data};
         pobs_n++;
      end
      if (rd[5] < cnt[5] && s_ready[6]) eth2_err++;
   end

   // ---------------- directed sequence ----------------
   initial begin
      int base;
      int start;
      logic [7:0] exp_user;

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_tvalid", to_valid, 1'b0);
      chk("rst_fields", {to_user, to_last, to_keep, to_data}, '0);
      chk("rst_tready", s_ready[4:0], 5'd0);
      chk("rst_state", dbg_state, 1'b0);
      chk("rst_grant", dbg_grant, 3'd0);
      chk("rst_rr_ptr", dbg_rr, 3'd0);
      chk("rst_occ", dbg_occ, 2'd0);
      chk("rst_prio_tvalid", p_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Round-robin: all five ports hold a 3-beat packet at once.
      // Priority instance: CPU 3 x 2-beat packets, ETH_2 2 x 2-beat packets.
      @(negedge clk);
      #1;
      for (int p = 0; p < 5; p++)
         for (int b = 0; b < 3; b++)
            add_beat(p, beat(mkd(p, b), 16'hFFFF, b == 2, {2'b00, addr(p), 3'(b)}));
      for (int k = 0; k < 6; k++)
         add_beat(5, beat(mkd(5, k), 16'hFFFF, (k % 2) == 1, 8'h08));
      for (int k = 0; k < 4; k++)
         add_beat(6, beat(mkd(6, k), 16'hFFFF, (k % 2) == 1, 8'h18));
      start = cyc + 1;
      wait_obs(0, 15, "rr_count");
      for (int k = 0; k < 15; k++)
         chk($sformatf("rr_beat%0d", k), obs_mem[k],
             beat(mkd(k / 3, k % 3), 16'hFFFF, (k % 3) == 2, {2'b00, addr(k / 3), 3'(k % 3)}));
      chk("rr_first_accept", acc_cyc[0], start + 1);
      chk("rr_first_out", obs_cyc[0], start + 2);
      for (int k = 1; k < 15; k++)
         chk($sformatf("rr_accept_gap%0d", k), acc_cyc[k] - acc_cyc[k - 1], ((k % 3) == 0) ? 2 : 1);
      for (int k = 0; k < 15; k++)
         chk($sformatf("rr_out_lat%0d", k), obs_cyc[k] - acc_cyc[k], 1);
      chk("rr_ptr_end", dbg_rr, 3'd0);

      wait_obs(1, 10, "prio_count");
      for (int k = 0; k < 10; k++)
         chk($sformatf("prio_beat%0d", k), pobs_mem[k],
             (k < 6) ? beat(mkd(5, k), 16'hFFFF, (k % 2) == 1, 8'h08)
                     : beat(mkd(6, k - 6), 16'hFFFF, (k % 2) == 1, 8'h18));
      chk("prio_eth2_ready", eth2_err, 0);

      // Backpressure: ETH_3 8-beat packet, sink ready 1,0,0 repeating.
      @(negedge clk);
      #1;
      base = obs_n;
      max_occ = 0;
      stab_err = 0;
      sink_mode = 1;
      for (int b = 0; b < 8; b++)
         add_beat(3, beat(128'(b), 16'hFFFF, b == 7, {2'b00, addr(3), 3'd2}));
      wait_obs(0, base + 8, "bp_count");
      sink_mode = 0;
      for (int b = 0; b < 8; b++) begin
         chk($sformatf("bp_data%0d", b), obs_mem[base + b][127:0], 128'(b));
         chk($sformatf("bp_last%0d", b), obs_mem[base + b][144], b == 7);
      end
      chk("bp_occ_max", max_occ, 2);
      chk("bp_out_stable", stab_err, 0);

      // Source stamping: ETH_4 packet with tuser_src = 0
      repeat (2) @(negedge clk);
      #1;
      base = obs_n;
      for (int b = 0; b < 2; b++)
         add_beat(4, beat(mkd(4, 20 + b), 16'hFFFF, b == 1, 8'h85));
`ifdef DPE_MUX_SRC_STAMP_EN
      exp_user = 8'hAD;
`else
      exp_user = 8'h85;
`endif
      wait_obs(0, base + 2, "stamp_count");
      for (int b = 0; b < 2; b++) begin
         chk($sformatf("stamp_user%0d", b), obs_mem[base + b][152:145], exp_user);
         chk($sformatf("stamp_bypass%0d", b), obs_mem[base + b][152:151], 2'b10);
         chk($sformatf("stamp_dst%0d", b), obs_mem[base + b][147:145], 3'd5);
         chk($sformatf("stamp_body%0d", b), obs_mem[base + b][144:0],
             {b == 1, 16'hFFFF, mkd(4, 20 + b)});
      end

      // Reset mid-packet: 5-beat CPU packet, reset after its second beat
      @(negedge clk);
      #1;
      base = obs_n;
      for (int b = 0; b < 5; b++)
         add_beat(0, beat(mkd(0, 10 + b), 16'hFFFF, b == 4, 8'h08));
      wait_obs(0, base + 2, "rstmid_pre_count");
      chk("rstmid_pre_valid", to_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rstmid_tvalid", to_valid, 1'b0);
      chk("rstmid_tready", s_ready[4:0], 5'd0);
      chk("rstmid_occ", dbg_occ, 2'd0);
      @(posedge clk);
      #2;
      cnt[0] = rd[0];   // the rest of the truncated packet is abandoned
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      add_beat(1, beat(mkd(1, 30), 16'h00FF, 1'b1, 8'hD6));
      start = cyc + 1;
      wait_obs(0, base + 3, "rstmid_count");
      chk("rstmid_cpu_beat0", obs_mem[base], beat(mkd(0, 10), 16'hFFFF, 1'b0, 8'h08));
      chk("rstmid_cpu_beat1", obs_mem[base + 1], beat(mkd(0, 11), 16'hFFFF, 1'b0, 8'h08));
      chk("rstmid_eth1_beat", obs_mem[base + 2], beat(mkd(1, 30), 16'h00FF, 1'b1, 8'hD6));
      chk("rstmid_eth1_latency", obs_cyc[base + 2], start + 2);
      repeat (5) @(negedge clk);
      #1;
      chk("rstmid_no_extra", obs_n, base + 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
